// File: rtl/addr_slave.sv
// Register-file responder for the addressed write/read bus.
// Four-phase write (input_en/ack) and read (output_en/data_valid) handshakes, plus dirty and collision tracking.
module addr_slave #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 3,
  parameter int                NUM_REGS  = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                slv_input_en,
  input  logic [ADDR_W-1:0]   slv_write_to,
  input  logic [DATA_W-1:0]   slv_data_in,
  output logic                slv_ack,
  input  logic                slv_output_en,
  input  logic [ADDR_W-1:0]   slv_read_from,
  output logic [DATA_W-1:0]   slv_data_out,
  output logic                slv_data_valid,
  output logic [NUM_REGS-1:0] slv_dirty,
  output logic [7:0]          slv_coll_cnt
);

  typedef enum logic [1:0] {IDLE, WR_HOLD, RD_HOLD} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_coll;

  logic [DATA_W-1:0]     r_regs [NUM_REGS];
  logic                  r_ack;
  logic                  r_valid;
  logic [DATA_W-1:0]     r_data_out;
  logic [NUM_REGS-1:0]   r_dirty;
  logic [7:0]            r_coll_cnt;

  // Requests are only accepted from IDLE; a write wins over a simultaneous read,
  // which simply stays pending on the bus until the write handshake finishes.
  always_comb begin
    w_state_next = r_state;
    w_wr_en      = 1'b0;
    w_rd_en      = 1'b0;
    w_coll       = 1'b0;
    case (r_state)
      IDLE: begin
        if (slv_input_en) begin
          w_wr_en      = 1'b1;
          w_coll       = slv_output_en;
          w_state_next = WR_HOLD;
        end else if (slv_output_en) begin
          w_rd_en      = 1'b1;
          w_state_next = RD_HOLD;
        end
      end
      WR_HOLD: if (!slv_input_en)  w_state_next = IDLE;
      RD_HOLD: if (!slv_output_en) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state    <= IDLE;
      r_ack      <= 1'b0;
      r_valid    <= 1'b0;
      r_data_out <= '0;
      r_dirty    <= '0;
      r_coll_cnt <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
    end else begin
      r_state <= w_state_next;
      // Handshake outputs simply mirror which hold state we are entering.
      r_ack   <= (w_state_next == WR_HOLD);
      r_valid <= (w_state_next == RD_HOLD);
      if (w_wr_en) begin
        r_regs[slv_write_to]  <= slv_data_in;
        r_dirty[slv_write_to] <= 1'b1;
      end
      if (w_rd_en) begin
        r_data_out             <= r_regs[slv_read_from];
        r_dirty[slv_read_from] <= 1'b0;
      end
      if (w_coll && (r_coll_cnt != 8'hFF)) r_coll_cnt <= r_coll_cnt + 8'd1;
    end
  end

  assign slv_ack        = r_ack;
  assign slv_data_valid = r_valid;
  assign slv_data_out   = r_data_out;
  assign slv_dirty      = r_dirty;
  assign slv_coll_cnt   = r_coll_cnt;

endmodule

// File: doc/addr_slave.md
Name: addr_slave

Overview:
- Responder end of the 8-bit addressed write/read bus driven by the address master.
- Holds an array of NUM_REGS data registers.
  - Master writes use a four-phase input_en/ack handshake.
  - Master reads use a four-phase output_en/data_valid handshake.
- Keeps per-register dirty flags (written since last read) and a saturating count of write/read request collisions, for system-level monitoring.

Parameters:
- DATA_W, 8, width of data bus and each register
- ADDR_W, 3, width of register address
- NUM_REGS, 8, number of registers; must equal 2**ADDR_W
- RESET_VAL, 8'h00, reset value of every register

Ports:
- clk_clk  input  1  single clock; all logic on rising edge
- reset_reset_n  input  1  asynchronous active-low reset
- slv_input_en  input  1  master write request, held until slv_ack seen
- slv_write_to  input  ADDR_W  write register address
- slv_data_in  input  DATA_W  write data
- slv_ack  output  1  write acknowledge
- slv_output_en  input  1  master read request, held until slv_data_valid seen
- slv_read_from  input  ADDR_W  read register address
- slv_data_out  output  DATA_W  read data
- slv_data_valid  output  1  read data valid
- slv_dirty  output  NUM_REGS  bit i=1: reg i written since last read of reg i
- slv_coll_cnt  output  8  saturating collision counter

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all regs=RESET_VAL.
  - slv_ack=0, slv_data_valid=0, slv_data_out=0, slv_dirty=0, slv_coll_cnt=0.
- All outputs are registered.
- FSM states: IDLE, WR_HOLD, RD_HOLD.
- IDLE, slv_input_en=1 (write; has priority):
  - reg[slv_write_to] <= slv_data_in; dirty[slv_write_to] <= 1; slv_ack <= 1; go WR_HOLD.
  - slv_ack is visible 1 cycle after the request is sampled.
- IDLE, slv_input_en=0, slv_output_en=1 (read):
  - slv_data_out <= reg[slv_read_from]; slv_data_valid <= 1; dirty[slv_read_from] <= 0; go RD_HOLD.
  - Read latency is 1 cycle.
- IDLE, both requests=1 on the same edge:
  - Write is serviced.
  - slv_coll_cnt increments, saturating at 8'hFF.
  - The read stays pending and is serviced from IDLE after the write handshake completes, if slv_output_en is still 1.
- WR_HOLD:
  - slv_ack stays 1 while slv_input_en=1.
  - Address/data changes during the hold are ignored: no second write.
  - When slv_input_en=0 is sampled: slv_ack <= 0, go IDLE.
- RD_HOLD:
  - slv_data_valid stays 1 and slv_data_out stays stable while slv_output_en=1.
  - Writes are not accepted during the hold; slv_input_en waits.
  - When slv_output_en=0 is sampled: slv_data_valid <= 0, go IDLE.
  - slv_data_out retains the last read value after the hold.
- Minimum transaction: 3 cycles (request edge, release edge, return to IDLE). Back-to-back requests are accepted on the cycle after IDLE is re-entered.
- Out-of-range addresses are not possible: NUM_REGS = 2**ADDR_W.
- Reset asserted mid-handshake:
  - Everything returns to reset values immediately.
  - A request still high after release is treated as new: a held write re-writes the register and sets dirty again.

Test Plan:
- Reset, then write 8'hA5 to addr 3 (input_en held 4 cycles) -> slv_ack=1 on cycle 1 through one cycle after input_en drops; reg3=A5; slv_dirty=8'b0000_1000.
- Read addr 3 after the above -> slv_data_valid=1 and slv_data_out=A5 one cycle after output_en; slv_dirty=0; data_out holds A5 after valid drops.
- Write addr 5=8'h11 then change slv_data_in to 8'h22 during WR_HOLD -> reg5 stays 11; exactly one write occurs.
- input_en and output_en both raised same edge (write addr 1=8'h3C, read addr 1) -> write first, coll_cnt=1; after ack drops the read returns 3C.
- 300 simultaneous-request transactions -> slv_coll_cnt saturates at 8'hFF, no wrap.
- Assert reset_reset_n=0 during RD_HOLD, with regs previously written -> valid/ack/dirty/coll_cnt=0 asynchronously, all regs=8'h00, state IDLE; a read of any address after release returns 8'h00.
